// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder and its 4-bit slice.
//   NIBBLE_W : width of one slice pass
//   state_e  : controller state encoding (2'b11 unused, treated as IDLE)
package adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/rippleAdder_4bit.sv
// 4-bit ripple-carry adder slice, purely combinational.
//   a_i, b_i : nibble operands
//   c_i      : carry-in
//   s_o      : nibble sum
//   c_o      : carry-out of bit 3
module rippleAdder_4bit
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                c_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                c_o
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a 4-bit ripple
// slice, carry registered between passes. One addition in flight.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (a, b, cin); ready only in IDLE
//   out_valid/out_ready : result handshake (sum, cout, ovf); valid only in DONE
//   busy                : high while nibbles are being processed
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e                             state_q, state_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                               carry_q, carry_d;
  logic                               cout_q, cout_d;
  logic                               ovf_q, ovf_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;

  logic [NIBBLE_W-1:0]                sl_sum;
  logic                               sl_cout;

  rippleAdder_4bit u_slice (
    .a_i (a_q[idx_q]),
    .b_i (b_q[idx_q]),
    .c_i (carry_q),
    .s_o (sl_sum),
    .c_o (sl_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      RUN: begin
        busy           = 1'b1;
        sum_d[idx_q]   = sl_sum;
        carry_d        = sl_cout;
        if (idx_q == LAST_IDX) begin
          // Final nibble: sign bits of both operands and the fresh sum MSB
          // come straight from this pass, so ovf needs no extra cycle.
          cout_d  = sl_cout;
          ovf_d   = a_q[NIBBLES-1][NIBBLE_W-1] ^ b_q[NIBBLES-1][NIBBLE_W-1]
                  ^ sl_sum[NIBBLE_W-1] ^ sl_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        // IDLE, and the unused 2'b11 encoding behaves identically.
        in_ready = 1'b1;
        state_d  = IDLE;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: a WIDTH=16 and a WIDTH=4 instance.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=16 instance signals
  logic        iv16, ir16, ci16, ov16, or16, co16, of16, bz16;
  logic [15:0] a16, b16, s16;
  // WIDTH=4 instance signals
  logic        iv4, ir4, ci4, ov4, or4, co4, of4, bz4;
  logic [3:0]  a4, b4, s4;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(ci16), .out_valid(ov16), .out_ready(or16),
    .sum(s16), .cout(co16), .ovf(of16), .busy(bz16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(ci4), .out_valid(ov4), .out_ready(or4),
    .sum(s4), .cout(co4), .ovf(of4), .busy(bz4)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // {cout, ovf, sum}
  logic [17:0] q16[$];
  logic [5:0]  q4[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b} + 17'(c);
    return {t[16], (a[15] == b[15]) && (t[15] != a[15]), t[15:0]};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] t;
    t = {1'b0, a} + {1'b0, b} + 5'(c);
    return {t[4], (a[3] == b[3]) && (t[3] != a[3]), t[3:0]};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c);
    int w = 0;
    while (!ir16 && w < 50) begin @(negedge clk); w++; end
    check("send16_ready", 32'(ir16), 32'd1);
    if (!ir16) return;
    a16 = a; b16 = b; ci16 = c; iv16 = 1'b1;
    q16.push_back(model16(a, b, c));
    @(negedge clk);
    iv16 = 1'b0;
    check("run16_busy", 32'(bz16), 32'd1);
    check("run16_in_ready", 32'(ir16), 32'd0);
  endtask

  task automatic recv16(input int hold);
    int cnt = 0;
    logic [17:0] e;
    while (!ov16 && cnt < 100) begin @(negedge clk); cnt++; end
    check("recv16_valid", 32'(ov16), 32'd1);
    if (!ov16) return;
    check("recv16_latency", 32'(cnt), 32'd4);
    check("recv16_qsize", 32'(q16.size() > 0), 32'd1);
    if (q16.size() == 0) return;
    e = q16.pop_front();
    check("recv16_sum", 32'(s16), 32'(e[15:0]));
    check("recv16_cout", 32'(co16), 32'(e[17]));
    check("recv16_ovf", 32'(of16), 32'(e[16]));
    for (int i = 0; i < hold; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
      iv16 = ~iv16;
      @(negedge clk);
      check("hold16_sum", 32'(s16), 32'(e[15:0]));
      check("hold16_cout", 32'(co16), 32'(e[17]));
      check("hold16_in_ready", 32'(ir16), 32'd0);
      check("hold16_valid", 32'(ov16), 32'd1);
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
    check("post16_valid", 32'(ov16), 32'd0);
    check("post16_in_ready", 32'(ir16), 32'd1);
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int w = 0;
    while (!ir4 && w < 50) begin @(negedge clk); w++; end
    check("send4_ready", 32'(ir4), 32'd1);
    if (!ir4) return;
    a4 = a; b4 = b; ci4 = c; iv4 = 1'b1;
    q4.push_back(model4(a, b, c));
    @(negedge clk);
    iv4 = 1'b0;
    check("run4_busy", 32'(bz4), 32'd1);
  endtask

  task automatic recv4();
    int cnt = 0;
    logic [5:0] e;
    while (!ov4 && cnt < 100) begin @(negedge clk); cnt++; end
    check("recv4_valid", 32'(ov4), 32'd1);
    if (!ov4) return;
    check("recv4_latency", 32'(cnt), 32'd1);
    check("recv4_qsize", 32'(q4.size() > 0), 32'd1);
    if (q4.size() == 0) return;
    e = q4.pop_front();
    check("recv4_sum", 32'(s4), 32'(e[3:0]));
    check("recv4_cout", 32'(co4), 32'(e[5]));
    check("recv4_ovf", 32'(of4), 32'(e[4]));
    or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
    check("post4_valid", 32'(ov4), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    iv16 = 0; ci16 = 0; or16 = 0; a16 = '0; b16 = '0;
    iv4  = 0; ci4  = 0; or4  = 0; a4  = '0; b4  = '0;
    repeat (2) @(negedge clk);
    check("rst16_sum", 32'(s16), 32'd0);
    check("rst16_cout", 32'(co16), 32'd0);
    check("rst16_ovf", 32'(of16), 32'd0);
    check("rst16_in_ready", 32'(ir16), 32'd1);
    check("rst16_out_valid", 32'(ov16), 32'd0);
    check("rst16_busy", 32'(bz16), 32'd0);
    check("rst4_in_ready", 32'(ir4), 32'd1);
    check("rst4_sum", 32'(s4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    send16(16'h00FF, 16'h0001, 1'b0); recv16(0);
    send16(16'hFFFF, 16'h0000, 1'b1); recv16(0);
    send16(16'h7FFF, 16'h0001, 1'b0); recv16(0);
    send16(16'h8000, 16'h8000, 1'b0); recv16(0);

    // Backpressure with junk on the input side, then a clean add
    send16(16'h1111, 16'h2222, 1'b0); recv16(5);
    send16(16'h0F0F, 16'hF0F0, 1'b1); recv16(0);
    check("bp_queue_empty", 32'(q16.size()), 32'd0);

    // Reset while idx==2
    send16(16'hAAAA, 16'h5555, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(ov16), 32'd0);
    check("midrst_in_ready", 32'(ir16), 32'd1);
    check("midrst_sum", 32'(s16), 32'd0);
    check("midrst_busy", 32'(bz16), 32'd0);
    if (q16.size() > 0) void'(q16.pop_back());
    send16(16'h1234, 16'h4321, 1'b0); recv16(0);

    for (int i = 0; i < 100; i++) begin
      send16(16'($urandom), 16'($urandom), 1'($urandom));
      recv16(int'($urandom_range(0, 2)));
    end

    // WIDTH=4 build
    send4(4'hF, 4'h1, 1'b0); recv4();
    for (int i = 0; i < 1000; i++) begin
      send4(4'($urandom), 4'($urandom), 1'($urandom));
      recv4();
    end
    check("final_q4_empty", 32'(q4.size()), 32'd0);
    check("final_q16_empty", 32'(q16.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
